// File: rtl/pcie_ats_inv_responder_pkg.sv
// Shared constants and types for the ATS invalidation responder: TLP header
// field offsets, message/routing codes and the queued invalidation entry.
package pcie_ats_pkg;

    localparam int REQ_TYPE_LSB = 75;
    localparam int REQ_ID_LSB   = 80;
    localparam int TAG_LSB      = 96;
    localparam int MSG_CODE_LSB = 104;
    localparam int ROUTE_LSB    = 112;

    localparam logic [3:0] REQ_TYPE_MSG_ID  = 4'b1110;
    localparam logic [2:0] ROUTE_BY_ID      = 3'b010;
    localparam logic [7:0] DEF_INV_REQ_CODE = 8'h01;
    localparam logic [7:0] DEF_INV_CPL_CODE = 8'h02;

    typedef struct packed {
        logic [15:0] requester_id;
        logic [7:0]  tag;
    } inv_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/pcie_ats_inv_responder_if.sv
// AXI-stream bundle used for the CQ input, the user-logic output and the RQ
// completion output of the ATS invalidation responder.
interface pcie_ats_axis_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 228
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tlast;
    logic [USER_W-1:0]   tuser;
    logic                tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/pcie_ats_inv_responder_fifo.sv
// Pending-invalidation FIFO: DEPTH entries of {requester_id, tag}; pointers
// carry one extra bit so full and empty are distinguishable.
module ats_inv_fifo
    import pcie_ats_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  inv_entry_t               wr_data,
    input  logic                     pop,
    output inv_entry_t               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    inv_entry_t   mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is left unreset; occupancy is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/pcie_ats_inv_responder.sv
// ATS Invalidate Request snooper on the CQ stream; queues requests and emits
// one Invalidate Completion each on RQ. Optional macro: ATS_INV_FILTER_EN.
module pcie_ats_inv_responder
    import pcie_ats_pkg::*;
#(
    parameter int         AXIS_DATA_WIDTH  = 512,
    parameter int         AXIS_TUSER_WIDTH = 228,
    parameter int         QUEUE_DEPTH      = 8,
    parameter logic [7:0] INV_REQ_CODE     = DEF_INV_REQ_CODE,
    parameter logic [7:0] INV_CPL_CODE     = DEF_INV_CPL_CODE
) (
    input  logic                           clk,
    input  logic                           rst,
    pcie_ats_axis_if.slave                 s_axis,
    pcie_ats_axis_if.master                m_axis,
    pcie_ats_axis_if.master                rq_axis,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
    output logic [31:0]                    inv_rx_count,
    output logic [31:0]                    inv_cpl_count,
    output logic                           ats_hit,
    output logic [7:0]                     ats_tag
);
    rsp_state_t  state_q;
    logic        rq_valid_q;
    inv_entry_t  desc_q;
    logic [31:0] cpl_cnt_q;
    logic        sop_q, sop_d;
    logic        hit_q, hit_d;
    logic [7:0]  tag_q, tag_d;
    logic [31:0] rx_cnt_q, rx_cnt_d;

    inv_entry_t  rx_entry, fifo_rd;
    logic        fifo_full, fifo_empty;
    logic        is_inv, pop, stall, beat_acc, push;

    assign rx_entry = {s_axis.tdata[REQ_ID_LSB +: 16], s_axis.tdata[TAG_LSB +: 8]};
    assign is_inv   = sop_q &&
                      (s_axis.tdata[REQ_TYPE_LSB +: 4] == REQ_TYPE_MSG_ID) &&
                      (s_axis.tdata[MSG_CODE_LSB +: 8] == INV_REQ_CODE);

    // Pop when idle with work pending, or when the current completion retires.
    assign pop   = !fifo_empty && ((state_q == ST_IDLE) ||
                                   ((state_q == ST_SEND) && rq_axis.tready));
    assign stall = s_axis.tvalid && is_inv && fifo_full && !pop;

`ifdef ATS_INV_FILTER_EN
    logic filt_q, filt_d;
    logic consume;

    assign consume       = is_inv || (!sop_q && filt_q);
    assign s_axis.tready = consume ? !stall : (m_axis.tready && !stall);
    assign m_axis.tvalid = s_axis.tvalid && !stall && !consume;
`else
    assign s_axis.tready = m_axis.tready && !stall;
    assign m_axis.tvalid = s_axis.tvalid && !stall;
`endif

    assign m_axis.tdata = s_axis.tdata;
    assign m_axis.tkeep = s_axis.tkeep;
    assign m_axis.tlast = s_axis.tlast;
    assign m_axis.tuser = s_axis.tuser;

    assign beat_acc = s_axis.tvalid && s_axis.tready;
    assign push     = beat_acc && is_inv;

    always_comb begin
        sop_d    = beat_acc ? s_axis.tlast : sop_q;
        hit_d    = push;
        tag_d    = push ? rx_entry.tag : tag_q;
        rx_cnt_d = rx_cnt_q + {31'd0, push};
`ifdef ATS_INV_FILTER_EN
        filt_d = filt_q;
        if (beat_acc) filt_d = s_axis.tlast ? 1'b0 : (sop_q ? is_inv : filt_q);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sop_q    <= 1'b1;
            hit_q    <= 1'b0;
            tag_q    <= '0;
            rx_cnt_q <= '0;
`ifdef ATS_INV_FILTER_EN
            filt_q   <= 1'b0;
`endif
        end else begin
            sop_q    <= sop_d;
            hit_q    <= hit_d;
            tag_q    <= tag_d;
            rx_cnt_q <= rx_cnt_d;
`ifdef ATS_INV_FILTER_EN
            filt_q   <= filt_d;
`endif
        end
    end

    ats_inv_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (rx_entry),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (queue_level)
    );

    // Completion FSM: the descriptor only changes on a retiring handshake,
    // so RQ data stays stable while tready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rq_valid_q <= 1'b0;
            desc_q     <= '0;
            cpl_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        desc_q     <= fifo_rd;
                        rq_valid_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (rq_axis.tready) begin
                        cpl_cnt_q <= cpl_cnt_q + 32'd1;
                        if (pop) begin
                            desc_q <= fifo_rd;
                        end else begin
                            rq_valid_q <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rq_axis.tdata = '0;
        rq_axis.tdata[REQ_TYPE_LSB +: 4] = REQ_TYPE_MSG_ID;
        rq_axis.tdata[REQ_ID_LSB +: 16]  = desc_q.requester_id;
        rq_axis.tdata[TAG_LSB +: 8]      = desc_q.tag;
        rq_axis.tdata[MSG_CODE_LSB +: 8] = INV_CPL_CODE;
        rq_axis.tdata[ROUTE_LSB +: 3]    = ROUTE_BY_ID;
        rq_axis.tkeep = '0;
        rq_axis.tkeep[15:0] = '1;
    end

    assign rq_axis.tvalid = rq_valid_q;
    assign rq_axis.tlast  = rq_valid_q;
    assign rq_axis.tuser  = '0;

    assign inv_rx_count  = rx_cnt_q;
    assign inv_cpl_count = cpl_cnt_q;
    assign ats_hit       = hit_q;
    assign ats_tag       = tag_q;
endmodule
